// File: rtl/segment_selector.sv
// Weighted (roulette) segment picker: accumulates the effective weights of the active
// table entries, draws an LFSR-scaled target below the total, and scans for the winner.
module segment_selector #(
  parameter int          MAX_SEGMENTS = 8,
  parameter int          IDX_W        = 3,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                    in_clock,
  input  logic                    in_reset_n,
  input  logic                    in_wr_en,
  input  logic [IDX_W-1:0]        in_wr_addr,
  input  logic signed [7:0]       in_wr_from,
  input  logic signed [7:0]       in_wr_to,
  input  logic [1:0]              in_wr_type,
  input  logic [7:0]              in_wr_weight,
  input  logic                    in_start,
  input  logic [IDX_W:0]          in_num_segments,
  output logic signed [7:0]       out_from,
  output logic signed [7:0]       out_to,
  output logic [1:0]              out_type,
  output logic [7:0]              out_weight,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_valid,
  output logic                    out_error,
  output logic                    out_busy
);

  localparam int             TOT_W    = 8 + IDX_W;
  localparam logic [15:0]    SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [IDX_W:0] MAX_N    = (IDX_W + 1)'(MAX_SEGMENTS);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAW, S_SCAN, S_DONE} state_e;

  logic signed [7:0] from_mem   [MAX_SEGMENTS];
  logic signed [7:0] to_mem     [MAX_SEGMENTS];
  logic [1:0]        type_mem   [MAX_SEGMENTS];
  logic [7:0]        weight_mem [MAX_SEGMENTS];

  state_e             state_q;
  logic [IDX_W:0]     n_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TOT_W-1:0]   total_q, cum_q, target_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [TOT_W-1:0]   ew, cum_d, target_d;
  logic [TOT_W+15:0]  product;
  logic               last_idx;

  always_comb begin
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    product  = {{TOT_W{1'b0}}, lfsr_d} * {16'h0, total_q};
    target_d = TOT_W'(product >> 16);
    ew       = '0;
    if ((type_mem[idx_q] != 2'd0) && ({1'b0, idx_q} < n_q))
      ew = {{IDX_W{1'b0}}, weight_mem[idx_q]};
    cum_d    = cum_q + ew;
    last_idx = ({1'b0, idx_q} == (n_q - 1'b1));
  end

  // NOTE: the table is plain storage with no reset, so it stays a RAM-friendly array.
  always_ff @(posedge in_clock) begin
    if (in_wr_en && !out_busy) begin
      from_mem[in_wr_addr]   <= in_wr_from;
      to_mem[in_wr_addr]     <= in_wr_to;
      type_mem[in_wr_addr]   <= in_wr_type;
      weight_mem[in_wr_addr] <= in_wr_weight;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      n_q        <= '0;
      idx_q      <= '0;
      total_q    <= '0;
      cum_q      <= '0;
      target_q   <= '0;
      out_from   <= '0;
      out_to     <= '0;
      out_type   <= '0;
      out_weight <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      out_error  <= 1'b0;
      out_busy   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            n_q      <= ((in_num_segments == '0) || (in_num_segments > MAX_N)) ? MAX_N
                                                                              : in_num_segments;
            total_q  <= '0;
            idx_q    <= '0;
            out_busy <= 1'b1;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          total_q <= total_q + ew;
          if (last_idx) begin
            idx_q   <= '0;
            state_q <= S_DRAW;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DRAW: begin
          if (total_q == '0) begin
            out_error <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            cum_q    <= '0;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          cum_q <= cum_d;
          if (target_q < cum_d) begin
            out_from   <= from_mem[idx_q];
            out_to     <= to_mem[idx_q];
            out_type   <= type_mem[idx_q];
            out_weight <= weight_mem[idx_q];
            out_index  <= idx_q;
            out_valid  <= 1'b1;
            state_q    <= S_DONE;
          end else if (last_idx) begin
            // Unreachable while target < total; kept so the scan can never run away.
            out_error <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          out_error <= 1'b0;
          out_busy  <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_selector.sv
// Directed bench for segment_selector: a reference model of the table, LFSR and roulette
// draw pushes expected results into a queue that is drained as each strobe appears.
module tb_segment_selector;

  logic              in_clock = 1'b0;
  logic              in_reset_n = 1'b0;
  logic              in_wr_en = 1'b0;
  logic [2:0]        in_wr_addr = '0;
  logic signed [7:0] in_wr_from = '0;
  logic signed [7:0] in_wr_to = '0;
  logic [1:0]        in_wr_type = '0;
  logic [7:0]        in_wr_weight = '0;
  logic              in_start = 1'b0;
  logic [3:0]        in_num_segments = '0;
  logic signed [7:0] out_from;
  logic signed [7:0] out_to;
  logic [1:0]        out_type;
  logic [7:0]        out_weight;
  logic [2:0]        out_index;
  logic              out_valid;
  logic              out_error;
  logic              out_busy;

  segment_selector dut (
    .in_clock(in_clock), .in_reset_n(in_reset_n),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_from(in_wr_from),
    .in_wr_to(in_wr_to), .in_wr_type(in_wr_type), .in_wr_weight(in_wr_weight),
    .in_start(in_start), .in_num_segments(in_num_segments),
    .out_from(out_from), .out_to(out_to), .out_type(out_type), .out_weight(out_weight),
    .out_index(out_index), .out_valid(out_valid), .out_error(out_error), .out_busy(out_busy)
  );

  always #5 in_clock = ~in_clock;

  typedef struct {
    bit                err;
    logic signed [7:0] from;
    logic signed [7:0] to;
    logic [1:0]        typ;
    logic [7:0]        weight;
    logic [2:0]        index;
    int                latency;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  logic signed [7:0] m_from   [8];
  logic signed [7:0] m_to     [8];
  logic [1:0]        m_type   [8];
  logic [7:0]        m_weight [8];
  logic [15:0]       m_lfsr;
  exp_t              prev;
  exp_t              sb[$];
  int                hist[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_reset_n = 1'b0;
    in_start   = 1'b0;
    in_wr_en   = 1'b0;
    repeat (2) @(posedge in_clock);
    #1 in_reset_n = 1'b1;
    m_lfsr      = 16'hACE1;
    prev.err    = 1'b0;
    prev.from   = '0;
    prev.to     = '0;
    prev.typ    = '0;
    prev.weight = '0;
    prev.index  = '0;
    prev.latency = 0;
  endtask

  task automatic write_entry(input int addr, input logic signed [7:0] f,
                             input logic signed [7:0] t, input logic [1:0] ty,
                             input logic [7:0] w);
    in_wr_en     = 1'b1;
    in_wr_addr   = 3'(addr);
    in_wr_from   = f;
    in_wr_to     = t;
    in_wr_type   = ty;
    in_wr_weight = w;
    @(posedge in_clock);
    #1 in_wr_en  = 1'b0;
    m_from[addr]   = f;
    m_to[addr]     = t;
    m_type[addr]   = ty;
    m_weight[addr] = w;
  endtask

  // Reference roulette draw: Fibonacci LFSR with taps 16,14,13,11 and scaled target.
  task automatic model_select(input int n_req);
    exp_t        e;
    int          n, total, cum, k;
    int          ew[8];
    int          taps[4];
    logic        fb;
    logic [15:0] r;
    longint      prod;
    taps = '{16, 14, 13, 11};
    n = (n_req == 0 || n_req > 8) ? 8 : n_req;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      ew[i] = (i < n && m_type[i] != 2'd0) ? int'(m_weight[i]) : 0;
      total += ew[i];
    end
    e = prev;
    e.err = (total == 0);
    if (total == 0) begin
      e.latency = n + 2;
    end else begin
      fb = 1'b0;
      for (int j = 0; j < 4; j++) fb ^= m_lfsr[16 - taps[j]];
      r = {fb, m_lfsr[15:1]};
      m_lfsr = r;
      prod = longint'(r) * longint'(total);
      cum = 0;
      k = 0;
      for (int i = 0; i < n; i++) begin
        cum += ew[i];
        if (longint'(cum) > (prod >>> 16)) begin
          k = i;
          break;
        end
      end
      e.from    = m_from[k];
      e.to      = m_to[k];
      e.typ     = m_type[k];
      e.weight  = m_weight[k];
      e.index   = 3'(k);
      e.latency = n + 3 + k;
      prev = e;
    end
    sb.push_back(e);
  endtask

  // Pulses start, optionally pokes start/write while busy, then checks the strobe cycle.
  task automatic start_and_wait(input int n, input bit disturb);
    exp_t e;
    int   cyc;
    in_num_segments = 4'(n);
    in_start = 1'b1;
    @(posedge in_clock);
    #1 in_start = 1'b0;
    cyc = 1;
    if (disturb) begin
      in_start = 1'b1;
      in_wr_en = 1'b1;
    end
    while (!(out_valid || out_error) && cyc < 200) begin
      @(posedge in_clock);
      #1 cyc++;
      if (disturb) begin
        in_start = (cyc < 4);
        in_wr_en = (cyc < 4);
      end
    end
    in_start = 1'b0;
    in_wr_en = 1'b0;
    e = sb.pop_front();
    check("latency", cyc, e.latency);
    check("valid", out_valid, !e.err);
    check("error", out_error, e.err);
    check("busy_at_strobe", out_busy, 1'b1);
    check("from", out_from, e.from);
    check("to", out_to, e.to);
    check("type", out_type, e.typ);
    check("weight", out_weight, e.weight);
    check("index", out_index, e.index);
    hist[out_index]++;
    @(posedge in_clock);
    #1;
    check("strobe_clear", {out_valid, out_error}, 2'b00);
    check("busy_clear", out_busy, 1'b0);
  endtask

  initial begin
    int strobes;
    int in_range;

    // Reset state.
    do_reset();
    check("rst_valid", out_valid, 1'b0);
    check("rst_error", out_error, 1'b0);
    check("rst_busy", out_busy, 1'b0);
    check("rst_from", out_from, 8'sd0);
    check("rst_to", out_to, 8'sd0);
    check("rst_type", out_type, 2'd0);
    check("rst_weight", out_weight, 8'd0);
    check("rst_index", out_index, 3'd0);

    // Single entry, N=1: valid at cycle 4.
    write_entry(0, -8'sd5, 8'sd10, 2'd3, 8'd7);
    model_select(1);
    start_and_wait(1, 1'b0);

    // Only entry 2 carries weight: always index 2, valid at cycle 9.
    write_entry(0, -8'sd20, -8'sd10, 2'd3, 8'd0);
    write_entry(1, -8'sd9, 8'sd0, 2'd3, 8'd0);
    write_entry(2, 8'sd1, 8'sd30, 2'd3, 8'd5);
    write_entry(3, 8'sd40, 8'sd90, 2'd3, 8'd0);
    for (int i = 0; i < 50; i++) begin
      model_select(4);
      start_and_wait(4, 1'b0);
    end

    // Entry 1 has type 0, so only entry 0 is selectable.
    write_entry(0, -8'sd3, 8'sd3, 2'd2, 8'd4);
    write_entry(1, 8'sd7, 8'sd8, 2'd0, 8'd4);
    for (int i = 0; i < 10; i++) begin
      model_select(2);
      start_and_wait(2, 1'b0);
    end

    // No weight anywhere: error at cycle 4, fields keep their prior values.
    write_entry(0, -8'sd3, 8'sd3, 2'd2, 8'd0);
    write_entry(1, 8'sd7, 8'sd8, 2'd1, 8'd0);
    model_select(2);
    start_and_wait(2, 1'b0);

    // start/write while busy are ignored; entry 0 must still have zero weight afterwards.
    write_entry(0, 8'sd11, 8'sd12, 2'd3, 8'd0);
    write_entry(1, 8'sd21, 8'sd22, 2'd1, 8'd9);
    in_wr_addr = 3'd0;
    in_wr_from = 8'sd99;
    in_wr_to = 8'sd100;
    in_wr_type = 2'd3;
    in_wr_weight = 8'd200;
    model_select(2);
    start_and_wait(2, 1'b1);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge in_clock);
      #1 if (out_valid || out_error) strobes++;
    end
    check("no_extra_strobe", strobes, 0);
    model_select(1);
    start_and_wait(1, 1'b0);

    // N=0 clamps to the full table; only the last entry is selectable.
    for (int i = 0; i < 7; i++) write_entry(i, 8'(i), 8'(i + 1), 2'd3, 8'd0);
    write_entry(7, -8'sd128, 8'sd127, 2'd1, 8'd3);
    model_select(0);
    start_and_wait(0, 1'b0);

    // Uniform weights from a fresh seed: bit-exact sequence and a flat histogram.
    do_reset();
    for (int i = 0; i < 4; i++) write_entry(i, 8'(10 * i), 8'(10 * i + 5), 2'd3, 8'd1);
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int i = 0; i < 4000; i++) begin
      model_select(4);
      start_and_wait(4, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      in_range = (hist[i] >= 900 && hist[i] <= 1100) ? 1 : 0;
      check($sformatf("hist_%0d_count_%0d", i, hist[i]), in_range, 1);
    end

    // Reset during SCAN aborts silently; the next draw repeats the post-seed first pick.
    do_reset();
    in_num_segments = 4'd4;
    in_start = 1'b1;
    @(posedge in_clock);
    #1 in_start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge in_clock);
      #1;
    end
    check("pre_abort_busy", out_busy, 1'b1);
    check("pre_abort_valid", out_valid, 1'b0);
    in_reset_n = 1'b0;
    #1;
    check("abort_busy", out_busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_error", out_error, 1'b0);
    #4 in_reset_n = 1'b1;
    @(posedge in_clock);
    #1;
    m_lfsr = 16'hACE1;
    model_select(4);
    start_and_wait(4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
